fifo_stream_checker: RTL

//  Read-side consumer/checker for a FiFo_Async pop port; the counterpart of the write-side stimulus generator.

---
 rtl/fifo_stream_checker_pkg.sv | 17 +
 rtl/fifo_stream_checker_if.sv | 11 +
 rtl/fifo_stream_checker_watchdog.sv | 29 ++
 rtl/fifo_stream_checker.sv | 128 ++++++++++++
 4 files changed

// File: rtl/fifo_stream_checker_pkg.sv
// Shared types and defaults for the FIFO read-side stream checker.
package fifo_stream_checker_pkg;

    localparam int unsigned THROTTLE_WIDTH         = 4;
    localparam int unsigned DEF_DATA_WIDTH         = 32;
    localparam int unsigned DEF_COUNT_WIDTH        = 16;
    localparam int unsigned DEF_ERR_WIDTH          = 8;
    localparam int unsigned DEF_TIMEOUT_CYCLES     = 1024;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/fifo_stream_checker_if.sv
// Show-ahead FIFO pop port: master is the consumer, slave is the FIFO.
interface fifo_stream_checker_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  R_nEN;
    logic [DATA_WIDTH-1:0] R_DATA;
    logic                  R_EMPTY;

    modport master (output R_nEN, input R_DATA, input R_EMPTY);
    modport slave  (input R_nEN, output R_DATA, output R_EMPTY);
endinterface

// File: rtl/fifo_stream_checker_watchdog.sv
// Empty-stall watchdog: counts consecutive stalled pop cycles and flags the limit.
module fifo_stream_checker_watchdog
    import fifo_stream_checker_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic MCLK,
    input  logic nRST,
    input  logic stall,
    output logic expire_c
);
    localparam int unsigned STALL_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_WIDTH-1:0] stall_cnt;

    // Fires on the stall cycle that makes TIMEOUT_CYCLES consecutive stalls.
    assign expire_c = stall && (stall_cnt == STALL_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
        end else if (!stall || expire_c) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + STALL_WIDTH'(1);
        end
    end

endmodule

// File: rtl/fifo_stream_checker.sv
// Read-side consumer: pops COUNT words, checks an incrementing sequence, reports errors.
// Optional empty-stall watchdog enabled by defining FIFO_CHECKER_TIMEOUT_EN.
module fifo_stream_checker
    import fifo_stream_checker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned COUNT_WIDTH    = DEF_COUNT_WIDTH,
    parameter int unsigned ERR_WIDTH      = DEF_ERR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      MCLK,
    input  logic                      nRST,
    input  logic                      START,
    input  logic [DATA_WIDTH-1:0]     EXPECT_FIRST,
    input  logic [COUNT_WIDTH-1:0]    COUNT,
    input  logic [THROTTLE_WIDTH-1:0] THROTTLE,
    fifo_stream_checker_if.master     rd,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      INTR,
    output logic [ERR_WIDTH-1:0]      ERR_CNT,
    output logic [DATA_WIDTH-1:0]     ERR_DATA,
    output logic                      TIMEOUT
);
    state_e                    state;
    logic [DATA_WIDTH-1:0]     expected;
    logic [COUNT_WIDTH-1:0]    remaining;
    logic [THROTTLE_WIDTH-1:0] gap_cnt;
    logic                      pop_c;
    logic                      mismatch_c;
    logic                      timeout_hit_c;

    // Pop only from S_POP and only when the FIFO has a word; drops with reset.
    assign pop_c      = (state == S_POP) && !rd.R_EMPTY;
    assign rd.R_nEN   = ~pop_c;
    assign mismatch_c = (rd.R_DATA != expected);

`ifdef FIFO_CHECKER_TIMEOUT_EN
    fifo_stream_checker_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .MCLK     (MCLK),
        .nRST     (nRST),
        .stall    ((state == S_POP) && rd.R_EMPTY),
        .expire_c (timeout_hit_c)
    );
`else
    // No watchdog in this build; the parameter only keeps the interface uniform.
    assign timeout_hit_c = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            state     <= S_IDLE;
            expected  <= '0;
            remaining <= '0;
            gap_cnt   <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            INTR      <= 1'b0;
            ERR_CNT   <= '0;
            ERR_DATA  <= '0;
            TIMEOUT   <= 1'b0;
        end else begin
            INTR <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        expected  <= EXPECT_FIRST;
                        remaining <= COUNT;
                        ERR_CNT   <= '0;
                        ERR_DATA  <= '0;
                        TIMEOUT   <= 1'b0;
                        if (COUNT == '0) begin
                            state <= S_DONE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            INTR  <= 1'b1;
                        end else begin
                            state <= S_POP;
                            BUSY  <= 1'b1;
                            DONE  <= 1'b0;
                        end
                    end
                end
                S_POP: begin
                    if (pop_c) begin
                        if (mismatch_c) begin
                            if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + ERR_WIDTH'(1);
                            if (ERR_CNT == '0) ERR_DATA <= rd.R_DATA;
                        end
                        // Resync to the observed word so a single drop costs one error.
                        expected  <= rd.R_DATA + DATA_WIDTH'(1);
                        remaining <= remaining - COUNT_WIDTH'(1);
                        if (remaining == COUNT_WIDTH'(1)) begin
                            state <= S_DONE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            INTR  <= 1'b1;
                        end else if (THROTTLE != '0) begin
                            state   <= S_GAP;
                            gap_cnt <= THROTTLE;
                        end
                    end else if (timeout_hit_c) begin
                        state   <= S_DONE;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                        INTR    <= 1'b1;
                        TIMEOUT <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == THROTTLE_WIDTH'(1)) begin
                        state <= S_POP;
                    end else begin
                        gap_cnt <= gap_cnt - THROTTLE_WIDTH'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule
